// File: rtl/mem_bus_ctrl.sv
// Load/store bus controller below the MEM stage: aligns, byte-enables and extends data accesses.
// Latency: detect in cycle N, bus request from N+1, data and stall release earliest at N+2.
// Backpressure: StallOut holds the pipeline from detect until DONE. Illegal accesses are not stalled.
//
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort a request after TIMEOUT REQ cycles without ack.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   MemReadIn, MemWriteIn         load / store request from the MEM stage
//   AddrIn, WriteDataIn, Funct3In byte address, LSB-justified store data, access size/sign
//   ReadDataOut                   extended load result, updated only on load completion
//   StallOut                      hold upstream pipeline registers
//   ErrOut                        one-cycle pulse on misaligned/illegal/conflict/timeout
//   BusReqOut, BusWeOut           bus request (held until ack), write enable
//   BusAddrOut, BusBeOut          word address, byte enables
//   BusWdataOut                   store data shifted into its byte lane
//   BusAckIn, BusRdataIn          single-cycle acknowledge, read word valid with ack
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] WriteDataIn,
  input  logic [2:0]  Funct3In,
  output logic [31:0] ReadDataOut,
  output logic        StallOut,
  output logic        ErrOut,
  output logic        BusReqOut,
  output logic        BusWeOut,
  output logic [31:0] BusAddrOut,
  output logic [3:0]  BusBeOut,
  output logic [31:0] BusWdataOut,
  input  logic        BusAckIn,
  input  logic [31:0] BusRdataIn
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Access decode (only acted on in IDLE)
  // ---------------------------------------------------------------------------
  logic       access;
  logic [1:0] lane;
  logic       is_half;
  logic       is_word;
  logic       illegal_f3;
  logic       misaligned;
  logic       store_bad;
  logic       conflict;
  logic       bad_access;
  logic       start;
  logic [3:0] be_c;
  logic [31:0] wdata_c;

  assign access  = MemReadIn | MemWriteIn;
  assign lane    = AddrIn[1:0];
  assign is_half = (Funct3In[1:0] == 2'b01);
  assign is_word = (Funct3In[1:0] == 2'b10);

  // 011, 111 (size field 11) and 110 (unsigned word) have no meaning.
  assign illegal_f3 = (Funct3In[1:0] == 2'b11) || (Funct3In == 3'b110);
  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  // Stores have no signedness; the unsigned encodings are rejected.
  assign store_bad  = MemWriteIn && Funct3In[2];
  assign conflict   = MemReadIn && MemWriteIn;

  assign bad_access = access && (conflict || illegal_f3 || store_bad || misaligned);
  assign start      = access && !bad_access;

  always_comb begin
    be_c = 4'b0000;
    unique case (Funct3In[1:0])
      2'b00:   be_c = 4'b0001 << lane;
      2'b01:   be_c = 4'b0011 << lane;
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  assign wdata_c = WriteDataIn << {lane, 3'b000};

  // ---------------------------------------------------------------------------
  // Load extraction from the returned bus word
  // ---------------------------------------------------------------------------
  logic        ld_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_lane_q;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  assign rdata_shifted = BusRdataIn >> {ld_lane_q, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    unique case (ld_f3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional request timeout
  // ---------------------------------------------------------------------------
  logic timeout_hit;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [31:0] to_cnt_q;

  // Counts REQ cycles; fires in the TIMEOUT-th REQ cycle that sees no ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= 32'h0;
    end else if (state_q == REQ) begin
      to_cnt_q <= to_cnt_q + 32'h1;
    end else begin
      to_cnt_q <= 32'h0;
    end
  end

  assign timeout_hit = (state_q == REQ) && !BusAckIn && (to_cnt_q == TIMEOUT_LAST);
`else
  // No counter: REQ waits for ack indefinitely. TIMEOUT stays referenced so
  // both builds share one parameter list.
  assign timeout_hit = 1'b0 && (TIMEOUT == 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic stall_c;

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall in the detect cycle so the pipeline holds the access.
        if (start) begin
          stall_c = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (BusAckIn || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances on this edge; the held access must not restart.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the stall low even if the MEM stage is still presenting an access.
  assign StallOut = stall_c & rst;

  // ---------------------------------------------------------------------------
  // Registered bus outputs, error pulse and load result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ReadDataOut <= 32'h0;
      ErrOut      <= 1'b0;
      BusReqOut   <= 1'b0;
      BusWeOut    <= 1'b0;
      BusAddrOut  <= 32'h0;
      BusBeOut    <= 4'b0000;
      BusWdataOut <= 32'h0;
      ld_q        <= 1'b0;
      ld_f3_q     <= 3'b000;
      ld_lane_q   <= 2'b00;
    end else begin
      ErrOut <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bad_access) begin
            ErrOut <= 1'b1;
          end else if (start) begin
            BusReqOut   <= 1'b1;
            BusWeOut    <= MemWriteIn;
            BusAddrOut  <= {AddrIn[31:2], 2'b00};
            BusBeOut    <= be_c;
            BusWdataOut <= MemWriteIn ? wdata_c : 32'h0;
            ld_q        <= MemReadIn;
            ld_f3_q     <= Funct3In;
            ld_lane_q   <= lane;
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (BusAckIn) begin
            BusReqOut <= 1'b0;
            if (ld_q) begin
              ReadDataOut <= load_ext;
            end
          end else if (timeout_hit) begin
            BusReqOut <= 1'b0;
            ErrOut    <= 1'b1;
            if (ld_q) begin
              ReadDataOut <= ERR_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: loads, stores, error pulses, stray acks and mid-request reset.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [31:0] AddrIn;
  logic [31:0] WriteDataIn;
  logic [2:0]  Funct3In;
  logic [31:0] ReadDataOut;
  logic        StallOut;
  logic        ErrOut;
  logic        BusReqOut;
  logic        BusWeOut;
  logic [31:0] BusAddrOut;
  logic [3:0]  BusBeOut;
  logic [31:0] BusWdataOut;
  logic        BusAckIn;
  logic [31:0] BusRdataIn;

  int passes = 0;
  int total  = 0;

  // Observations from the last transaction
  int          stall_cnt;
  int          req_cnt;
  logic        cap_req;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  mem_bus_ctrl #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemReadIn   (MemReadIn),
    .MemWriteIn  (MemWriteIn),
    .AddrIn      (AddrIn),
    .WriteDataIn (WriteDataIn),
    .Funct3In    (Funct3In),
    .ReadDataOut (ReadDataOut),
    .StallOut    (StallOut),
    .ErrOut      (ErrOut),
    .BusReqOut   (BusReqOut),
    .BusWeOut    (BusWeOut),
    .BusAddrOut  (BusAddrOut),
    .BusBeOut    (BusBeOut),
    .BusWdataOut (BusWdataOut),
    .BusAckIn    (BusAckIn),
    .BusRdataIn  (BusRdataIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    MemReadIn   = 1'b0;
    MemWriteIn  = 1'b0;
    AddrIn      = 32'h0;
    WriteDataIn = 32'h0;
    Funct3In    = 3'b000;
  endtask

  // Presents an access and plays the bus: ack in the ack_at-th REQ cycle.
  // Returns in the first cycle with StallOut low (DONE), inputs still held.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input int ack_at, input logic [31:0] rdata);
    MemReadIn   = rd;
    MemWriteIn  = wr;
    AddrIn      = addr;
    WriteDataIn = wd;
    Funct3In    = f3;
    #1;
    stall_cnt = 0;
    req_cnt   = 0;
    cap_req   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!StallOut) break;
      stall_cnt++;
      if (BusReqOut) req_cnt++;
      if (c == 1) begin
        cap_req   = BusReqOut;
        cap_we    = BusWeOut;
        cap_addr  = BusAddrOut;
        cap_be    = BusBeOut;
        cap_wdata = BusWdataOut;
      end
      if (c == ack_at) begin
        BusAckIn   = 1'b1;
        BusRdataIn = rdata;
      end
      @(posedge clk);
      #1;
      BusAckIn   = 1'b0;
      BusRdataIn = 32'h0;
      #1;
    end
  endtask

  // Illegal access: no stall in the detect cycle, error pulse next cycle only.
  task automatic err_case(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rd_hold);
    MemReadIn  = rd;
    MemWriteIn = wr;
    AddrIn     = addr;
    Funct3In   = f3;
    #1;
    chk({tag, "_stall"}, StallOut, 1'b0);
    tick();
    set_idle();
    #1;
    chk({tag, "_err"}, ErrOut, 1'b1);
    chk({tag, "_req"}, BusReqOut, 1'b0);
    chk({tag, "_rd"}, ReadDataOut, rd_hold);
    tick();
    chk({tag, "_err_end"}, ErrOut, 1'b0);
    chk({tag, "_req_end"}, BusReqOut, 1'b0);
  endtask

  initial begin
    rst        = 1'b0;
    BusAckIn   = 1'b0;
    BusRdataIn = 32'h0;
    set_idle();
    #3;
    chk("rst_rd", ReadDataOut, 32'h0);
    chk("rst_stall", StallOut, 1'b0);
    chk("rst_err", ErrOut, 1'b0);
    chk("rst_req", BusReqOut, 1'b0);
    chk("rst_we", BusWeOut, 1'b0);
    chk("rst_addr", BusAddrOut, 32'h0);
    chk("rst_be", {28'h0, BusBeOut}, 32'h0);
    chk("rst_wdata", BusWdataOut, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // LW 0x100, ack in second REQ cycle
    xact(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 2, 32'hCAFE_F00D);
    chk("lw_stall", stall_cnt, 3);
    chk("lw_req", cap_req, 1'b1);
    chk("lw_we", cap_we, 1'b0);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_be", {28'h0, cap_be}, 32'hF);
    chk("lw_rd", ReadDataOut, 32'hCAFE_F00D);
    chk("lw_req_done", BusReqOut, 1'b0);
    chk("lw_err", ErrOut, 1'b0);
    set_idle();
    tick();
    chk("lw_idle_stall", StallOut, 1'b0);

    // LB 0x203 -> byte 0x80 sign-extended
    xact(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 1, 32'h8011_2233);
    chk("lb_stall", stall_cnt, 2);
    chk("lb_addr", cap_addr, 32'h200);
    chk("lb_be", {28'h0, cap_be}, 32'h8);
    chk("lb_rd", ReadDataOut, 32'hFFFF_FF80);
    set_idle();
    tick();

    // LBU 0x203
    xact(1'b1, 1'b0, 32'h203, 32'h0, 3'b100, 1, 32'h8011_2233);
    chk("lbu_rd", ReadDataOut, 32'h0000_0080);
    set_idle();
    tick();

    // LH / LHU 0x102 -> half 0x8011
    xact(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 3, 32'h8011_2233);
    chk("lh_stall", stall_cnt, 4);
    chk("lh_be", {28'h0, cap_be}, 32'hC);
    chk("lh_rd", ReadDataOut, 32'hFFFF_8011);
    set_idle();
    tick();
    xact(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 1, 32'h8011_2233);
    chk("lhu_rd", ReadDataOut, 32'h0000_8011);
    set_idle();
    tick();

    // SH 0x102
    xact(1'b0, 1'b1, 32'h102, 32'h0000_1234, 3'b001, 1, 32'hFFFF_FFFF);
    chk("sh_stall", stall_cnt, 2);
    chk("sh_we", cap_we, 1'b1);
    chk("sh_addr", cap_addr, 32'h100);
    chk("sh_be", {28'h0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'h1234_0000);
    chk("sh_rd_hold", ReadDataOut, 32'h0000_8011);
    set_idle();
    tick();

    // SB 0x101, SW 0x104
    xact(1'b0, 1'b1, 32'h101, 32'h0000_00AB, 3'b000, 1, 32'h0);
    chk("sb_be", {28'h0, cap_be}, 32'h2);
    chk("sb_wdata", cap_wdata, 32'h0000_AB00);
    set_idle();
    tick();
    xact(1'b0, 1'b1, 32'h104, 32'h55AA_1234, 3'b010, 1, 32'h0);
    chk("sw_addr", cap_addr, 32'h104);
    chk("sw_be", {28'h0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h55AA_1234);
    chk("sw_rd_hold", ReadDataOut, 32'h0000_8011);
    set_idle();
    tick();

    // Rejected accesses
    err_case("lw_misal", 1'b1, 1'b0, 32'h101, 3'b010, 32'h0000_8011);
    err_case("conflict", 1'b1, 1'b1, 32'h100, 3'b010, 32'h0000_8011);
    err_case("lh_misal", 1'b1, 1'b0, 32'h103, 3'b001, 32'h0000_8011);
    err_case("sbu_store", 1'b0, 1'b1, 32'h100, 3'b100, 32'h0000_8011);
    err_case("f3_011", 1'b1, 1'b0, 32'h100, 3'b011, 32'h0000_8011);

    // Stray ack in IDLE is ignored
    BusAckIn   = 1'b1;
    BusRdataIn = 32'h1234_5678;
    tick();
    BusAckIn   = 1'b0;
    BusRdataIn = 32'h0;
    #1;
    chk("stray_ack_rd", ReadDataOut, 32'h0000_8011);
    chk("stray_ack_stall", StallOut, 1'b0);

    // Reset while in REQ
    MemReadIn = 1'b1;
    AddrIn    = 32'h300;
    Funct3In  = 3'b010;
    tick();
    chk("rstreq_req", BusReqOut, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstreq_req_drop", BusReqOut, 1'b0);
    chk("rstreq_stall", StallOut, 1'b0);
    chk("rstreq_rd", ReadDataOut, 32'h0);
    set_idle();
    #1;
    rst = 1'b1;
    tick();
    xact(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 1, 32'h0BAD_F00D);
    chk("after_rst_stall", stall_cnt, 2);
    chk("after_rst_rd", ReadDataOut, 32'h0BAD_F00D);
    set_idle();
    tick();

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: 4 REQ cycles, then abort with ERR_DATA; a late ack is ignored.
    xact(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 99, 32'h0);
    chk("to_stall", stall_cnt, 5);
    chk("to_req_cycles", req_cnt, 4);
    chk("to_req_drop", BusReqOut, 1'b0);
    chk("to_err", ErrOut, 1'b1);
    chk("to_rd", ReadDataOut, 32'hDEAD_BEEF);
    set_idle();
    BusAckIn   = 1'b1;
    BusRdataIn = 32'h1111_1111;
    tick();
    BusAckIn   = 1'b0;
    BusRdataIn = 32'h0;
    #1;
    chk("to_err_end", ErrOut, 1'b0);
    chk("to_late_ack_rd", ReadDataOut, 32'hDEAD_BEEF);
    chk("to_late_ack_stall", StallOut, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
